// File: rtl/systolic_seq_ctrl.sv
// Job sequencer for the weight-stationary systolic array: weight load, input streaming,
// and latency tracking so each result vector can be flagged valid, then a done pulse.
module systolic_seq_ctrl #(
   parameter int ADDR_BW  = 8,
   parameter int PIPE_LAT = 8
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               start,
   input  logic               abort,
   input  logic [ADDR_BW-1:0] num_vec,
   input  logic               w_ready,
   output logic               we_rl,
   output logic               din_rd_en,
   output logic [ADDR_BW-1:0] din_rd_addr,
   output logic               din_valid,
   output logic               res_valid,
   output logic [ADDR_BW-1:0] res_idx,
   output logic               busy,
   output logic               done
);

   typedef enum logic [2:0] {
      IDLE,
      WWAIT,
      WLOAD,
      FEED,
      DRAIN,
      DONE
   } state_t;

   localparam logic [ADDR_BW-1:0] ONE = ADDR_BW'(1);

   state_t                r_state;
   state_t                w_nextState;
   logic [ADDR_BW-1:0]    r_numVec;
   logic [ADDR_BW-1:0]    r_addr;
   logic [ADDR_BW-1:0]    r_resIdx;
   logic                  r_dinValid;
   logic [PIPE_LAT-1:0]   r_lat;
   logic [PIPE_LAT-1:0]   w_latNext;
   logic                  w_accept;
   logic                  w_abort;
   logic                  w_feedLast;

   assign w_accept   = (r_state == IDLE) && start && !abort;
   assign w_abort    = (r_state != IDLE) && abort;
   assign w_feedLast = (r_addr == (r_numVec - ONE));

   // Contents the latency line will hold after this edge; DRAIN ends once that is empty.
   generate
      if (PIPE_LAT == 1) begin : g_latShort
         assign w_latNext = r_dinValid;
      end else begin : g_latLong
         assign w_latNext = {r_lat[PIPE_LAT-2:0], r_dinValid};
      end
   endgenerate

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_nextState = WWAIT;
         WWAIT:   if (w_ready) w_nextState = WLOAD;
         WLOAD:   w_nextState = (r_numVec != '0) ? FEED : DONE;
         FEED:    if (w_feedLast) w_nextState = DRAIN;
         DRAIN:   if (w_latNext == '0) w_nextState = DONE;
         DONE:    w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
      if (w_abort) begin
         w_nextState = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_numVec   <= '0;
         r_addr     <= '0;
         r_resIdx   <= '0;
         r_dinValid <= 1'b0;
         r_lat      <= '0;
      end else begin
         if (w_accept) begin
            r_numVec <= num_vec;
         end

         if (w_accept || w_abort) begin
            r_addr <= '0;
         end else if (r_state == FEED) begin
            r_addr <= r_addr + ONE;
         end

         // An abort flushes everything in flight so no stale result is flagged.
         r_dinValid <= (r_state == FEED) && !w_abort;
         r_lat      <= w_abort ? '0 : w_latNext;

         if (w_accept) begin
            r_resIdx <= '0;
         end else if (r_lat[PIPE_LAT-1]) begin
            r_resIdx <= r_resIdx + ONE;
         end
      end
   end

   assign we_rl       = (r_state == WLOAD);
   assign din_rd_en   = (r_state == FEED);
   assign din_rd_addr = din_rd_en ? r_addr : '0;
   assign din_valid   = r_dinValid;
   assign res_valid   = r_lat[PIPE_LAT-1];
   assign res_idx     = r_resIdx;
   assign busy        = (r_state != IDLE);
   assign done        = (r_state == DONE);

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed bench for systolic_seq_ctrl: expected output events are queued when a job is
// started and matched (cycle and value) by a monitor as the controller produces them.
module tb_systolic_seq_ctrl;

   localparam int AW = 8;
   localparam int L  = 8;

   typedef struct {
      int cyc;
      int val;
   } ev_t;

   logic          clk = 1'b0;
   logic          rstn;
   logic          start;
   logic          abort;
   logic [AW-1:0] num_vec;
   logic          w_ready;
   logic          we_rl;
   logic          din_rd_en;
   logic [AW-1:0] din_rd_addr;
   logic          din_valid;
   logic          res_valid;
   logic [AW-1:0] res_idx;
   logic          busy;
   logic          done;

   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   int   base;
   int   endCyc;
   ev_t  weQ[$];
   ev_t  rdQ[$];
   ev_t  dvQ[$];
   ev_t  resQ[$];
   ev_t  doneQ[$];

   systolic_seq_ctrl #(.ADDR_BW(AW), .PIPE_LAT(L)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .start       (start),
      .abort       (abort),
      .num_vec     (num_vec),
      .w_ready     (w_ready),
      .we_rl       (we_rl),
      .din_rd_en   (din_rd_en),
      .din_rd_addr (din_rd_addr),
      .din_valid   (din_valid),
      .res_valid   (res_valid),
      .res_idx     (res_idx),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int allOutputs();
      return int'({we_rl, din_rd_en, din_rd_addr, din_valid, res_valid, res_idx, busy, done});
   endfunction

   function automatic int queuedTotal();
      return weQ.size() + rdQ.size() + dvQ.size() + resQ.size() + doneQ.size();
   endfunction

   // Expected event times are relative to the cycle before WWAIT (the accepting edge).
   task automatic pushJob(input int b, input int n, input int stall, input int resCount,
                          input bit withDone);
      weQ.push_back('{b + 2 + stall, 1});
      for (int i = 0; i < n; i++) begin
         rdQ.push_back('{b + 3 + stall + i, i});
         dvQ.push_back('{b + 4 + stall + i, 1});
      end
      for (int i = 0; i < resCount; i++) begin
         resQ.push_back('{b + L + 4 + stall + i, i});
      end
      if (withDone) begin
         doneQ.push_back('{(n == 0) ? (b + 3 + stall) : (b + L + n + 4 + stall), 1});
      end
   endtask

   task automatic applyStimulus(input int n, input logic wr);
      num_vec = AW'(n);
      w_ready = wr;
      start   = 1'b1;
      tick();
      start   = 1'b0;
      base    = cyc - 1;
   endtask

   task automatic waitIdle(output int lastCyc);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 300) begin
         tick();
         n++;
      end
      checkOutput("idle_timeout", int'(n < 300), 1);
      lastCyc = cyc;
   endtask

   always @(negedge clk) begin
      ev_t e;
      if (rstn === 1'b1) begin
         if (we_rl) begin
            checkOutput("we_expected", int'(weQ.size() > 0), 1);
            if (weQ.size() > 0) begin
               e = weQ.pop_front();
               checkOutput("we_cycle", cyc, e.cyc);
            end
         end
         if (din_rd_en) begin
            checkOutput("rd_expected", int'(rdQ.size() > 0), 1);
            if (rdQ.size() > 0) begin
               e = rdQ.pop_front();
               checkOutput("rd_cycle", cyc, e.cyc);
               checkOutput("rd_addr", int'(din_rd_addr), e.val);
            end
         end
         if (din_valid) begin
            checkOutput("dv_expected", int'(dvQ.size() > 0), 1);
            if (dvQ.size() > 0) begin
               e = dvQ.pop_front();
               checkOutput("dv_cycle", cyc, e.cyc);
            end
         end
         if (res_valid) begin
            checkOutput("res_expected", int'(resQ.size() > 0), 1);
            if (resQ.size() > 0) begin
               e = resQ.pop_front();
               checkOutput("res_cycle", cyc, e.cyc);
               checkOutput("res_idx", int'(res_idx), e.val);
            end
         end
         if (done) begin
            checkOutput("done_expected", int'(doneQ.size() > 0), 1);
            if (doneQ.size() > 0) begin
               e = doneQ.pop_front();
               checkOutput("done_cycle", cyc, e.cyc);
            end
         end
      end
   end

   initial begin
      rstn    = 1'b0;
      start   = 1'b0;
      abort   = 1'b0;
      num_vec = '0;
      w_ready = 1'b0;
      base    = 0;
      endCyc  = 0;
      tick();
      tick();
      checkOutput("reset_outputs", allOutputs(), 0);
      rstn = 1'b1;
      tick();
      checkOutput("post_reset_idle", int'(busy), 0);

      // Nominal N=4; num_vec changes and a start pulse arrive mid-job and must be ignored.
      applyStimulus(4, 1'b1);
      pushJob(base, 4, 0, 4, 1'b1);
      num_vec = 8'd9;
      repeat (4) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      waitIdle(endCyc);
      checkOutput("nom_busy_fall", endCyc - base, L + 4 + 5);
      checkOutput("nom_queues_empty", queuedTotal(), 0);
      repeat (3) tick();
      checkOutput("nom_no_requeue", int'(busy), 0);

      // Weight buffer not ready for 5 cycles.
      applyStimulus(3, 1'b0);
      pushJob(base, 3, 5, 3, 1'b1);
      for (int k = 0; k < 5; k++) begin
         checkOutput("stall_we", int'(we_rl), 0);
         checkOutput("stall_rd", int'(din_rd_en), 0);
         checkOutput("stall_busy", int'(busy), 1);
         tick();
      end
      w_ready = 1'b1;
      tick();
      tick();
      w_ready = 1'b0;
      waitIdle(endCyc);
      checkOutput("stall_busy_fall", endCyc - base, L + 3 + 5 + 5);
      checkOutput("stall_queues_empty", queuedTotal(), 0);

      // Weight load only.
      applyStimulus(0, 1'b1);
      pushJob(base, 0, 0, 0, 1'b1);
      waitIdle(endCyc);
      checkOutput("n0_busy_fall", endCyc - base, 4);
      checkOutput("n0_queues_empty", queuedTotal(), 0);

      // Abort in DRAIN at cycle 13: two results seen, no done.
      applyStimulus(4, 1'b1);
      pushJob(base, 4, 0, 2, 1'b0);
      repeat (12) tick();
      checkOutput("abort_at_cycle", cyc - base, 13);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checkOutput("abort_busy", int'(busy), 0);
      checkOutput("abort_res_valid", int'(res_valid), 0);
      checkOutput("abort_din_valid", int'(din_valid), 0);
      tick();
      checkOutput("abort_no_done", int'(done), 0);
      checkOutput("abort_queues_empty", queuedTotal(), 0);
      applyStimulus(2, 1'b1);
      pushJob(base, 2, 0, 2, 1'b1);
      waitIdle(endCyc);
      checkOutput("post_abort_busy_fall", endCyc - base, L + 2 + 5);
      checkOutput("post_abort_queues_empty", queuedTotal(), 0);

      // Start together with abort in IDLE.
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      checkOutput("start_abort_idle", int'(busy), 0);
      repeat (3) tick();
      checkOutput("start_abort_still_idle", int'(busy), 0);

      // Reset asserted mid-FEED, then a fresh job.
      applyStimulus(6, 1'b1);
      pushJob(base, 6, 0, 6, 1'b1);
      repeat (3) tick();
      checkOutput("rst_in_feed", int'(din_rd_en), 1);
      rstn = 1'b0;
      #1;
      checkOutput("rst_mid_outputs", allOutputs(), 0);
      weQ.delete();
      rdQ.delete();
      dvQ.delete();
      resQ.delete();
      doneQ.delete();
      tick();
      tick();
      rstn = 1'b1;
      tick();
      checkOutput("rst_release_idle", allOutputs(), 0);
      applyStimulus(3, 1'b1);
      pushJob(base, 3, 0, 3, 1'b1);
      waitIdle(endCyc);
      checkOutput("rst_fresh_busy_fall", endCyc - base, L + 3 + 5);
      checkOutput("rst_fresh_queues_empty", queuedTotal(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/systolic_seq_ctrl.md
Name: systolic_seq_ctrl

Overview:
Sequencer for the weight-stationary systolic array. It runs one job per start:
- waits for the weight buffer and pulses the weight-load enable (we_rl) into all PE rows;
- streams N input vectors from the input buffer into the array's DIN;
- tracks array latency so it can flag each valid result vector, then signals completion.
It sits between the host/command logic and the systolic top module plus its input buffer.

Parameters:
ADDR_BW, 8, input-buffer address width; also the width of the vector count and result index.
PIPE_LAT, 8, cycles from a vector appearing on DIN (din_valid high) to its result vector being valid at the array output; must be >= 1.

Ports:
clk  in  1  system clock, rising edge.
rstn  in  1  asynchronous active-low reset.
start  in  1  job request; sampled only in IDLE.
abort  in  1  synchronous job cancel.
num_vec  in  ADDR_BW  vectors to stream; latched on accepted start; 0 means weight load only.
w_ready  in  1  weight buffer holds a valid WEIGHTS word.
we_rl  out  1  weight-load enable to the array.
din_rd_en  out  1  input-buffer read enable.
din_rd_addr  out  ADDR_BW  input-buffer read address.
din_valid  out  1  DIN carries a valid vector this cycle (buffer read latency is 1 cycle).
res_valid  out  1  array result vector is valid this cycle.
res_idx  out  ADDR_BW  index of the current result vector (0..N-1).
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rstn=0, asynchronous): state=IDLE. All outputs are 0. Vector counter, latency shift register and result index are cleared.
- All outputs are registered or decoded from registered state. No combinational path from any input to any output.
- States: IDLE, WWAIT, WLOAD, FEED, DRAIN, DONE.
- IDLE:
  - start=1 and abort=0: latch num_vec into N, go to WWAIT.
  - start=1 and abort=1: stay in IDLE.
- WWAIT: go to WLOAD on the first cycle w_ready=1. Stay indefinitely otherwise.
- WLOAD: lasts exactly 1 cycle with we_rl=1.
  - N>0: go to FEED.
  - N=0: go to DONE.
- FEED: lasts exactly N cycles.
  - din_rd_en=1 every cycle; din_rd_addr = 0, 1, ..., N-1 on consecutive cycles.
  - After the N-th read, go to DRAIN.
- din_valid is din_rd_en delayed 1 cycle.
- res_valid is din_valid delayed PIPE_LAT cycles, via a PIPE_LAT-deep shift register.
- res_idx is 0 on the first res_valid of a job and increments after each res_valid. It is cleared on an accepted start.
- DRAIN: go to DONE the cycle after the last res_valid, i.e. once both din_valid and the shift register are empty.
- DONE: done=1 for 1 cycle, then go to IDLE.
- busy=1 in WWAIT, WLOAD, FEED, DRAIN and DONE.
- abort=1 in any non-IDLE state:
  - next cycle the state is IDLE;
  - we_rl, din_rd_en, din_valid and res_valid are 0, and the shift register is flushed;
  - done is not pulsed.
- start while busy is ignored and not queued.
- w_ready dropping after WLOAD has no effect.
- Reset asserted mid-job: immediate return to the reset state; no done.
- Counters: the read address never wraps within a job (N <= 2^ADDR_BW-1). Index arithmetic is unsigned modulo 2^ADDR_BW.

Timing (start accepted at edge 0, w_ready=1, L=PIPE_LAT):
- WWAIT in cycle 1.
- we_rl=1 in cycle 2.
- din_rd_en=1 in cycles 3..N+2.
- din_valid=1 in cycles 4..N+3.
- res_valid=1 in cycles L+4..L+N+3.
- done=1 in cycle L+N+4.
- busy=0 from cycle L+N+5.

Test Plan:
- Reset: rstn low mid-FEED -> all outputs 0 within the reset cycle; state IDLE after release; a new start begins a fresh job with addr 0.
- Nominal: N=4, L=8, w_ready=1 -> we_rl cycle 2; rd_addr 0,1,2,3 in cycles 3-6; res_valid cycles 12-15 with res_idx 0-3; done cycle 16.
- Weight stall: w_ready=0 for 5 cycles after start -> controller holds WWAIT, we_rl=0 and rd_en=0 throughout; we_rl rises the cycle after w_ready goes high; the rest of the timing shifts by exactly 5 cycles.
- N=0: start with num_vec=0 -> one we_rl pulse, no rd_en, no res_valid, done 1 cycle after WLOAD.
- Abort during DRAIN (N=4, abort at cycle 13) -> res_valid=0 from cycle 14, no done, busy=0 at cycle 14; a second start at cycle 15 runs normally.
- Start while busy and start+abort together in IDLE -> both ignored; num_vec changing mid-job does not affect the latched N.
